// File: rtl/y_tap_line_buffer.sv
// y_tap_line_buffer: vertical tap gatherer for the y-direction weight tables.
// Keeps the three previous rows of a raster stream in line buffers and, for
// every accepted sample, registers the four vertically adjacent samples of
// that column (oldest on out_0, current on out_3). One cycle of latency and
// no backpressure. Tap sets are flagged valid only from row 3 of a frame on.
module y_tap_line_buffer #(
  parameter int DATA_W = 15,
  parameter int LINE_W = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_0,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [DATA_W-1:0] out_3,
  output logic [ADDR_W-1:0] out_col,
  output logic              out_eol
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_W - 1);

  // lb0 holds row r-1, lb1 row r-2, lb2 row r-3
  logic [DATA_W-1:0] lb0 [LINE_W];
  logic [DATA_W-1:0] lb1 [LINE_W];
  logic [DATA_W-1:0] lb2 [LINE_W];

  logic [ADDR_W-1:0] col;
  logic [1:0]        row_cnt;

  // Column and row this sample is placed at; in_sof forces row 0, col 0.
  logic [ADDR_W-1:0] c;
  logic [1:0]        row_use;
  logic              last;

  assign c       = in_sof ? '0 : col;
  assign row_use = in_sof ? 2'd0 : row_cnt;
  assign last    = (c == LAST_COL);

  // Column shift through the three line buffers; contents need no reset
  // because rows 0..2 of every frame are gated off the outputs.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb2[c] <= lb1[c];
      lb1[c] <= lb0[c];
      lb0[c] <= in_data;
    end
  end

  // Raster position; row count saturates at 3 since only "row >= 3" matters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col     <= '0;
      row_cnt <= 2'd0;
    end else if (in_valid) begin
      col     <= last ? '0 : c + 1'b1;
      row_cnt <= (last && row_use != 2'd3) ? row_use + 2'd1 : row_use;
    end
  end

  // Registered tap set; data outputs hold across input bubbles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_0     <= '0;
      out_1     <= '0;
      out_2     <= '0;
      out_3     <= '0;
      out_col   <= '0;
      out_eol   <= 1'b0;
    end else begin
      out_valid <= in_valid && (row_use == 2'd3);
      if (in_valid) begin
        out_0   <= lb2[c];
        out_1   <= lb1[c];
        out_2   <= lb0[c];
        out_3   <= in_data;
        out_col <= c;
        out_eol <= last;
      end
    end
  end

endmodule

// File: tb/tb_y_tap_line_buffer.sv
// Bench for y_tap_line_buffer (LINE_W=4). The reference model stores the
// current frame as a (row, col) addressed array and derives each expected tap
// set from rows r-3..r of that frame. A per-cycle scoreboard entry is pushed
// when stimulus is driven; a monitor pops and compares one cycle later.
module tb_y_tap_line_buffer;
  localparam int DW = 15;
  localparam int LW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_sof;
  logic [DW-1:0] in_data;
  logic          out_valid, out_eol;
  logic [DW-1:0] out_0, out_1, out_2, out_3;
  logic [AW-1:0] out_col;

  y_tap_line_buffer #(.DATA_W(DW), .LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_0(out_0), .out_1(out_1),
    .out_2(out_2), .out_3(out_3), .out_col(out_col), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            vld;
    bit            bub;
    logic [DW-1:0] t0, t1, t2, t3;
    logic [AW-1:0] col;
    bit            eol;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;

  // reference model: current frame contents and raster position
  logic [DW-1:0] fm [int];
  int            mr = 0, mc = 0;

  task automatic model_reset();
    fm.delete();
    mr = 0;
    mc = 0;
  endtask

  // Drive one cycle of stimulus and queue the response it must produce.
  task automatic drive(input bit v, input bit s, input logic [DW-1:0] d);
    exp_t e;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    e = '{vld: 1'b0, bub: 1'b1, t0: '0, t1: '0, t2: '0, t3: '0, col: '0, eol: 1'b0};
    if (v) begin
      if (s) model_reset();
      fm[mr*LW + mc] = d;
      e.bub = 1'b0;
      e.vld = (mr >= 3);
      if (mr >= 3) begin
        e.t0 = fm[(mr-3)*LW + mc];
        e.t1 = fm[(mr-2)*LW + mc];
        e.t2 = fm[(mr-1)*LW + mc];
      end
      e.t3  = d;
      e.col = AW'(mc);
      e.eol = (mc == LW-1);
      mc++;
      if (mc == LW) begin
        mc = 0;
        mr++;
      end
    end
    sb.push_back(e);
  endtask

  // Reset cycle with live-looking input; outputs must read all zero.
  task automatic reset_cycle();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_sof   = 1'($urandom);
    in_data  = DW'($urandom);
    model_reset();
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_0 !== '0 || out_1 !== '0 || out_2 !== '0 ||
        out_3 !== '0 || out_col !== '0 || out_eol !== 1'b0) begin
      fails++;
      $display("FAIL reset: got vld=%b taps=%h %h %h %h col=%0d eol=%b, want all zero",
               out_valid, out_0, out_1, out_2, out_3, out_col, out_eol);
    end
  endtask

  // Monitor: one scoreboard entry per driven cycle, checked after the edge.
  logic [DW-1:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  logic [AW-1:0] pcol = '0;
  logic          peol = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (e.bub) begin
          if (out_valid !== 1'b0 || out_0 !== p0 || out_1 !== p1 || out_2 !== p2 ||
              out_3 !== p3 || out_col !== pcol || out_eol !== peol) begin
            fails++;
            $display("FAIL bubble_hold: got vld=%b %h %h %h %h col=%0d eol=%b, want vld=0 %h %h %h %h col=%0d eol=%b",
                     out_valid, out_0, out_1, out_2, out_3, out_col, out_eol,
                     p0, p1, p2, p3, pcol, peol);
          end
        end else if (!e.vld) begin
          if (out_valid !== 1'b0 || out_3 !== e.t3 || out_col !== e.col || out_eol !== e.eol) begin
            fails++;
            $display("FAIL gated_row: got vld=%b out_3=%h col=%0d eol=%b, want vld=0 out_3=%h col=%0d eol=%b",
                     out_valid, out_3, out_col, out_eol, e.t3, e.col, e.eol);
          end
        end else begin
          if (out_valid !== 1'b1 || out_0 !== e.t0 || out_1 !== e.t1 || out_2 !== e.t2 ||
              out_3 !== e.t3 || out_col !== e.col || out_eol !== e.eol) begin
            fails++;
            $display("FAIL taps: got vld=%b %h %h %h %h col=%0d eol=%b, want vld=1 %h %h %h %h col=%0d eol=%b",
                     out_valid, out_0, out_1, out_2, out_3, out_col, out_eol,
                     e.t0, e.t1, e.t2, e.t3, e.col, e.eol);
          end
        end
      end
      p0 = out_0; p1 = out_1; p2 = out_2; p3 = out_3; pcol = out_col; peol = out_eol;
    end
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;

    // reset held with valid input present
    repeat (2) reset_cycle();

    // counters start at row 0, col 0 without any in_sof
    repeat (6) drive(1'b1, 1'b0, DW'($urandom));

    // fill and steady state: value = row*16 + col, rows 0..5, with bubbles
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < LW; c++) begin
        drive(1'b1, (r == 0 && c == 0), DW'(r*16 + c));
        if (r == 4 && c == 1) drive(1'b0, 1'b0, DW'($urandom));
        if (r == 5 && c == 1) repeat (3) drive(1'b0, 1'b1, DW'($urandom));
      end

    // new frame, then abort it at row 4 col 1 with a full-scale in_sof sample
    for (int k = 0; k < 4*LW + 1; k++) drive(1'b1, (k == 0), DW'($urandom));
    // restarted frame alternates full-scale rows 0x7FFF / 0x0000
    for (int k = 0; k < 6*LW; k++)
      drive(1'b1, (k == 0), ((k / LW) % 2 == 0) ? DW'(15'h7FFF) : DW'(0));

    // randomized traffic with bubbles and occasional restarts
    for (int k = 0; k < 400; k++)
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 2), DW'($urandom));

    // reset mid-frame, then continue without in_sof
    repeat (2) drive(1'b1, 1'b0, DW'($urandom));
    reset_cycle();
    for (int k = 0; k < 6*LW; k++) drive(1'b1, 1'b0, DW'($urandom));

    repeat (2) drive(1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/y_tap_line_buffer.md
Name: y_tap_line_buffer

Overview:
- Vertical tap gatherer sitting directly upstream of the y-direction weight tables.
- Accepts a raster stream of horizontally interpolated samples (15-bit, 8 integer + 7 fraction) and keeps the three previous rows in internal line buffers.
- For each incoming sample, presents the four vertically adjacent samples of that column as one registered tap set.
- Its four data outputs connect directly to in_0..in_3 of every y weight table.

Parameters:
- DATA_W, 15, sample width (8.7 fixed point).
- LINE_W, 64, samples per row; must be ≥ 2.
- ADDR_W, 6, column counter width; 2^ADDR_W ≥ LINE_W.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data holds a sample this cycle.
- in_sof  input  1  qualified by in_valid; marks the sample as row 0, column 0 of a new frame.
- in_data  input  DATA_W  horizontally interpolated sample.
- out_valid  output  1  tap set valid this cycle.
- out_0  output  DATA_W  sample from row r-3, same column (oldest).
- out_1  output  DATA_W  sample from row r-2.
- out_2  output  DATA_W  sample from row r-1.
- out_3  output  DATA_W  current sample, row r.
- out_col  output  ADDR_W  column index of the tap set.
- out_eol  output  1  tap set is the last column of its row.

Behaviour:
- Reset (rst==0 at clock edge):
  - col=0, row_cnt=0.
  - out_valid=0, out_eol=0, out_col=0, out_0..out_3=0.
  - Line buffer contents are not reset; they can never reach the outputs before being overwritten (see row gating).
- Storage: three arrays, lb0 (row r-1), lb1 (row r-2), lb2 (row r-3), each LINE_W x DATA_W.
- Accepted sample (in_valid==1) at column index c, where c = 0 if in_sof else col:
  - Read lb0[c], lb1[c], lb2[c] (pre-write values).
  - Write lb2[c]<=lb1[c], lb1[c]<=lb0[c], lb0[c]<=in_data.
  - Register out_0<=lb2[c], out_1<=lb1[c], out_2<=lb0[c], out_3<=in_data, out_col<=c, out_eol<=(c==LINE_W-1).
  - out_valid<=row_full, where row_full = (row used this sample ≥ 3).
- Latency: exactly 1 cycle from accepted input to output. No backpressure; one sample per cycle is sustained.
- Counters:
  - col increments per accepted sample.
  - At c==LINE_W-1, col wraps to 0 and row_cnt increments, saturating at 3.
- in_sof handling:
  - Sample is treated as col 0, row 0: row_cnt is taken as 0 for this sample's gating; next col=1 (or 0 with row_cnt=1 when LINE_W==1, which is disallowed), row_cnt=0.
  - An in_sof asserted mid-row or mid-frame aborts the current frame immediately.
  - Old buffer data is shifted in but is never exposed, because rows 0-2 of the new frame are gated.
- in_sof with in_valid==0: ignored.
- in_valid==0 cycle: counters and buffers hold; out_valid<=0; data outputs hold their last values.
- First three rows of a frame (row 0..2): out_valid=0. The buffers still fill.
- No top/bottom edge replication in this block; edge policy is handled by the frame source.
- Arithmetic: none; pure data movement. Widths are preserved exactly, with no truncation.
- Reset mid-frame: all counters clear; the next frame needs in_sof or starts at col 0, row 0.

Test Plan:
- Reset
  - Stimulus: hold rst=0 for 2 cycles with in_valid=1 and random data.
  - Required: out_valid=0, out_0..out_3=0, out_col=0 throughout; col and row_cnt remain 0 after release.
- Fill and first taps (LINE_W=4)
  - Stimulus: in_sof on the first sample, then 16 consecutive samples with value = row*16+col.
  - Required: out_valid=0 for the first 12 outputs. The 13th output, one cycle after row 3 col 0, is out_0=0x00, out_1=0x10, out_2=0x20, out_3=0x30, out_col=0.
  - Required: the 16th output has out_col=3, out_eol=1, out_3=0x33.
- Steady state / wrap
  - Stimulus: continue to row 5 col 2.
  - Required: taps are 0x22, 0x32, 0x42, 0x52, out_valid=1; row_cnt stays saturated.
- Bubbles
  - Stimulus: insert in_valid=0 gaps of 1 and 3 cycles mid-row.
  - Required: out_valid=0 during each gap, outputs held, and tap values identical to the gap-free run.
- Mid-frame restart
  - Stimulus: assert in_sof at row 4 col 1 with data 0x7FFF.
  - Required: the next 12 outputs have out_valid=0; the first valid tap set after restart has out_col=0, out_3 = new row 3 col 0 data, and no pre-restart value on any valid output.
- Full-scale data
  - Stimulus: drive 0x7FFF and 0x0000 in alternating rows.
  - Required: the value appears bit-exact on the correct out_k with no width truncation.
